// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with optional FWFT read, threshold flags, count, sticky errors and sync clear
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count_q, count_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  read_ok, write_ok;
    logic                  unused_msb;

    assign read_ok      = rd_en & ~empty;
    assign write_ok     = wr_en & (~full | read_ok);
    assign count        = count_q;
    assign full         = count_q == DEPTH_C;
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= AF_C;
    assign almost_empty = count_q <= AE_C;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign unused_msb   = rd_ptr_q[ADDR_WIDTH] ^ wr_ptr_q[ADDR_WIDTH];

    // next-state: clear wins and swallows any access in the same cycle
    always_comb begin
        rd_ptr_d = clr ? '0 : read_ok  ? rd_ptr_q + ONE : rd_ptr_q;
        wr_ptr_d = clr ? '0 : write_ok ? wr_ptr_q + ONE : wr_ptr_q;
        count_d  = clr ? '0 : (write_ok & ~read_ok) ? count_q + ONE :
                   (read_ok & ~write_ok) ? count_q - ONE : count_q;
        ovf_d    = ~clr & (ovf_q | (wr_en & ~write_ok));
        udf_d    = ~clr & (udf_q | (rd_en & ~read_ok));
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // storage array, not reset
    always_ff @(posedge clk) begin
        if (!clr && write_ok) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            // registered read: load head word on an accepted pop, hold otherwise
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dout_q <= '0;
                else if (clr) dout_q <= '0;
                else if (read_ok) dout_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
            assign dout = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed checks of standard and FWFT instances against a queue model
module tb_sync_fifo_flags;
    logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] din = '0, dout0, dout1;
    logic [4:0] count0, count1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [7:0] m [$];
    logic [7:0] sb [$];
    logic [7:0] exp_dout = '0;
    logic       ovf_m = 1'b0, udf_m = 1'b0;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(udf0));

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(udf1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int         n;
        logic [5:0] fl;
        n  = m.size();
        fl = {n == 16, n == 0, n >= 14, n <= 2, ovf_m, udf_m};
        chk("count_std", 32'(count0), 32'(n));
        chk("count_fwft", 32'(count1), 32'(n));
        chk("flags_std", 32'({full0, empty0, af0, ae0, ovf0, udf0}), 32'(fl));
        chk("flags_fwft", 32'({full1, empty1, af1, ae1, ovf1, udf1}), 32'(fl));
        chk("dout_std", 32'(dout0), 32'(exp_dout));
        if (n != 0) chk("dout_fwft", 32'(dout1), 32'(m[0]));
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic rok, wok;
        wr_en = w; din = d; rd_en = r; clr = c;
        rok = r && m.size() != 0;
        wok = w && (m.size() != 16 || rok);
        if (c) begin
            m.delete(); ovf_m = 1'b0; udf_m = 1'b0;
        end else begin
            if (rok) sb.push_back(m.pop_front());
            if (wok) m.push_back(d);
            ovf_m = ovf_m | (w && !wok);
            udf_m = udf_m | (r && !rok);
        end
        @(posedge clk);
        #1;
        if (c) exp_dout = '0;
        else if (sb.size() != 0) exp_dout = sb.pop_front();
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        check_all();
    endtask

    initial begin
        logic [7:0] pat [4];
        pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1, pat[i], 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'hEE, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 16; i++) cyc(1, 8'(i + 16), 0, 0);
        cyc(1, 8'h55, 1, 0);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h77, 1, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h3C, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        for (int i = 0; i < 9; i++) cyc(1, 8'(8'h90 + i), 0, 0);
        cyc(1, 8'hFF, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0, 0);
        cyc(0, 8'h00, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        m.delete(); sb.delete(); exp_dout = '0; ovf_m = 1'b0; udf_m = 1'b0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 8'h42, 0, 0);
        cyc(0, 8'h00, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
